matrix_stream_loader_3by3: RTL and testbench
============================================

# matrix_stream_loader_3by3

Upstream feeder for the combinational 3×3 signed 16-bit matrix multiplier. Accepts a serial valid/ready word stream carrying one A matrix then one B matrix, row-major. Deposits the words into 18 element registers and presents them in parallel with a valid/ready handshake. Holds the operands stable while the multiplier's Y outputs are consumed, and detects and drops malformed frames.

## Interface

Parameters: none. Element width is fixed at 16 bits signed to match the multiplier.

Ports:
- clk  in  1  sole clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- in_data  in  16  signed element word
- in_valid  in  1  in_data/in_last valid this cycle
- in_last  in  1  marks final word of a frame (must be word 17, zero-based)
- in_ready  out  1  loader accepts a word this cycle
- A11..A33  out  16 each, signed  A operand registers, row-major
- B11..B33  out  16 each, signed  B operand registers, row-major
- mat_valid  out  1  A/B registers hold a complete, well-formed frame
- mat_ready  in  1  consumer has taken the current frame's result
- frame_err  out  1  one-cycle pulse per malformed frame

## Operation

- Accept condition: in_valid & in_ready.
- Word index idx runs 0..17 and is 5 bits.
  - Words 0–8 map to A11,A12,A13,A21,…,A33.
  - Words 9–17 map to B11,…,B33.
- States: LOAD, DRAIN, HOLD.
- LOAD (in_ready=1, mat_valid=0):
  - An accepted word is written to the element selected by idx. No arithmetic and no width change.
  - idx<17, in_last=0: idx++.
  - idx<17, in_last=1 (short frame): pulse frame_err, idx←0, stay in LOAD.
  - idx==17, in_last=1: idx←0, go to HOLD.
  - idx==17, in_last=0 (long frame): pulse frame_err, idx←0, go to DRAIN.
- DRAIN (in_ready=1, mat_valid=0): discard accepted words and write no registers. An accepted word with in_last=1 returns to LOAD. No further frame_err for that frame.
- HOLD (in_ready=0, mat_valid=1): A/B registers frozen. mat_ready=1 moves to LOAD with idx=0.
- Element registers are not cleared after a handoff or an error. While mat_valid=0 their contents are don't-care for the consumer.
- Reset values:
  - state=LOAD, idx=0.
  - All A*/B* = 0.
  - mat_valid=0, frame_err=0.
  - in_ready=0 while rst=1.
- rst mid-frame or in HOLD:
  - The partial or held frame is abandoned.
  - No frame_err is issued.
  - The loader is ready for word 0 the cycle after rst deasserts.
- mat_ready is ignored outside HOLD.
- in_valid is ignored in HOLD, where in_ready=0. Upstream must hold the word.

## Timing

- in_ready = !rst & (state!=HOLD). It is a combinational decode of registered state only, with no path from in_valid.
- mat_valid and frame_err are registered.
- mat_valid rises the cycle after word 17 is accepted.
- A/B outputs are final in the same cycle mat_valid rises.
- Handoff:
  - The consumer samples the multiplier Y outputs in any cycle with mat_valid & mat_ready.
  - mat_valid falls the next cycle.
  - in_ready rises in that same next cycle.
- frame_err is high for exactly the cycle after the offending word is accepted.
- Throughput with in_valid and mat_ready held high is one frame per 19 cycles: 18 load cycles plus 1 HOLD cycle.
- in_valid gaps stretch LOAD without loss of idx.

## Test plan

- Reset then stream words 1..18 back-to-back (in_last on word 18), mat_ready=1:
  - mat_valid high for 1 cycle, starting the cycle after word 18.
  - A11=1, A33=9, B11=10, B33=18.
  - Multiplier Y11=84.
- Identity A (1,0,0,0,1,0,0,0,1), B = −5..3, mat_ready held low for 10 cycles:
  - mat_valid and in_ready=0 held for 10 cycles.
  - A/B stable; Y equals B.
  - Handoff happens on the cycle mat_ready rises.
- Short frame with in_last on word 5:
  - frame_err pulses once, mat_valid stays 0.
  - The next 18-word frame loads correctly.
- Long frame of 20 words with in_last on word 20:
  - frame_err pulses after word 18.
  - Words 19–20 are dropped.
  - The following valid frame yields mat_valid with correct values.
- Random in_valid gaps (~50% duty) over a frame of −32768 and 32767 values: registers hold exact values and sign is preserved.
- Assert rst at word 10, and separately during HOLD:
  - All outputs return to 0 / mat_valid=0, with no frame_err.
  - in_ready=1 the cycle after rst deasserts.

Source files
------------

// File: rtl/matrix_stream_loader_3by3.sv
`default_nettype none
// ============================================================================
// Module   : matrix_stream_loader_3by3
// Brief    : Collects an 18-word A/B operand stream for the 3x3 multiplier and
//            holds the operands until the consumer takes the result.
// Revision : 1.0 - initial release
// ============================================================================
module matrix_stream_loader_3by3 (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] in_data,
    input  logic        in_valid,
    input  logic        in_last,
    output logic        in_ready,
    output logic [15:0] A11,
    output logic [15:0] A12,
    output logic [15:0] A13,
    output logic [15:0] A21,
    output logic [15:0] A22,
    output logic [15:0] A23,
    output logic [15:0] A31,
    output logic [15:0] A32,
    output logic [15:0] A33,
    output logic [15:0] B11,
    output logic [15:0] B12,
    output logic [15:0] B13,
    output logic [15:0] B21,
    output logic [15:0] B22,
    output logic [15:0] B23,
    output logic [15:0] B31,
    output logic [15:0] B32,
    output logic [15:0] B33,
    output logic        mat_valid,
    input  logic        mat_ready,
    output logic        frame_err
);

    localparam logic [1:0] c_LOAD     = 2'd0;
    localparam logic [1:0] c_DRAIN    = 2'd1;
    localparam logic [1:0] c_HOLD     = 2'd2;
    localparam logic [4:0] c_LAST_IDX = 5'd17;

    logic [1:0]  r_state;
    logic [4:0]  r_idx;
    logic [15:0] r_elem [0:17];
    logic        r_mat_valid;
    logic        r_frame_err;
    logic        w_accept;
    logic        w_load_wr;

    // Ready depends only on registered state so there is no in_valid -> in_ready path.
    assign in_ready  = !rst && (r_state != c_HOLD);
    assign w_accept  = in_valid && in_ready;
    assign w_load_wr = w_accept && (r_state == c_LOAD);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_LOAD;
            r_idx       <= '0;
            r_mat_valid <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= 1'b0;
            case (r_state)
                c_LOAD: begin
                    if (w_accept) begin
                        if (r_idx == c_LAST_IDX) begin
                            r_idx <= '0;
                            if (in_last) begin
                                r_state     <= c_HOLD;
                                r_mat_valid <= 1'b1;
                            end else begin
                                r_state     <= c_DRAIN;
                                r_frame_err <= 1'b1;
                            end
                        end else if (in_last) begin
                            r_idx       <= '0;
                            r_frame_err <= 1'b1;
                        end else begin
                            r_idx <= r_idx + 5'd1;
                        end
                    end
                end
                c_DRAIN: begin
                    // Overlong frame: swallow words until its own last marker.
                    if (w_accept && in_last) begin
                        r_state <= c_LOAD;
                    end
                end
                c_HOLD: begin
                    if (mat_ready) begin
                        r_state     <= c_LOAD;
                        r_mat_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= c_LOAD;
                    r_idx       <= '0;
                    r_mat_valid <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 18; k++) begin
                r_elem[k] <= '0;
            end
        end else begin
            for (int k = 0; k < 18; k++) begin
                if (w_load_wr && (r_idx == 5'(k))) begin
                    r_elem[k] <= in_data;
                end
            end
        end
    end

    assign mat_valid = r_mat_valid;
    assign frame_err = r_frame_err;

    assign A11 = r_elem[0];
    assign A12 = r_elem[1];
    assign A13 = r_elem[2];
    assign A21 = r_elem[3];
    assign A22 = r_elem[4];
    assign A23 = r_elem[5];
    assign A31 = r_elem[6];
    assign A32 = r_elem[7];
    assign A33 = r_elem[8];
    assign B11 = r_elem[9];
    assign B12 = r_elem[10];
    assign B13 = r_elem[11];
    assign B21 = r_elem[12];
    assign B22 = r_elem[13];
    assign B23 = r_elem[14];
    assign B31 = r_elem[15];
    assign B32 = r_elem[16];
    assign B33 = r_elem[17];

endmodule
`default_nettype wire

// File: tb/tb_matrix_stream_loader_3by3.sv
`default_nettype none
// ============================================================================
// Module   : tb_matrix_stream_loader_3by3
// Brief    : Directed and randomized frame streams against a frame-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_matrix_stream_loader_3by3;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] in_data;
    logic        in_valid;
    logic        in_last;
    logic        in_ready;
    logic        mat_valid;
    logic        mat_ready;
    logic        frame_err;
    logic [15:0] el [18];

    int checks = 0;
    int errors = 0;
    int err_pulses;
    int err_word;
    logic [15:0] fw [20];

    always #5 clk = ~clk;

    matrix_stream_loader_3by3 dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_last(in_last), .in_ready(in_ready),
        .A11(el[0]),  .A12(el[1]),  .A13(el[2]),  .A21(el[3]),  .A22(el[4]),
        .A23(el[5]),  .A31(el[6]),  .A32(el[7]),  .A33(el[8]),
        .B11(el[9]),  .B12(el[10]), .B13(el[11]), .B21(el[12]), .B22(el[13]),
        .B23(el[14]), .B31(el[15]), .B32(el[16]), .B33(el[17]),
        .mat_valid(mat_valid), .mat_ready(mat_ready), .frame_err(frame_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    // One clock; outputs sampled 1ns after the edge. acc is the word index accepted at this edge.
    task automatic tick(input int acc);
        @(posedge clk);
        #1;
        if (frame_err === 1'b1) begin
            err_pulses++;
            err_word = acc;
        end
    endtask

    task automatic send_frame(input int n, input int last_pos, input int gap_pct);
        err_pulses = 0;
        err_word   = -1;
        for (int i = 0; i < n; i++) begin
            for (int g = 0; g < 4 && gap_pct > 0 && $urandom_range(99) < gap_pct; g++) begin
                in_valid = 1'b0;
                in_data  = 16'(($urandom));
                tick(-1);
            end
            chk("in_ready_stream", {31'd0, in_ready}, 32'd1);
            in_valid = 1'b1;
            in_data  = fw[i];
            in_last  = (i == last_pos);
            tick(i);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Frame-level rules: short frame errs at its last word, long frame errs at word 17.
    task automatic check_frame(input string tag, input int n, input int last_pos);
        int exp_word;
        logic exp_ok;
        exp_ok   = (n == 18) && (last_pos == 17);
        exp_word = (last_pos >= 0 && last_pos < 17) ? last_pos :
                   ((n > 18) ? 17 : -1);
        chk({tag, "_err_pulses"}, err_pulses, (exp_word >= 0) ? 1 : 0);
        chk({tag, "_err_word"}, err_word, exp_word);
        chk({tag, "_mat_valid"}, {31'd0, mat_valid}, {31'd0, exp_ok});
        if (exp_ok) begin
            for (int k = 0; k < 18; k++) begin
                chk($sformatf("%s_el%0d", tag, k), {16'd0, el[k]}, {16'd0, fw[k]});
            end
        end
    endtask

    function automatic int y_of(input logic [15:0] m [18], input int r, input int c);
        int s = 0;
        for (int k = 0; k < 3; k++) begin
            s += int'($signed(m[3*r+k])) * int'($signed(m[9+3*k+c]));
        end
        return s;
    endfunction

    task automatic check_zero(input string tag);
        for (int k = 0; k < 18; k++) begin
            chk($sformatf("%s_el%0d", tag, k), {16'd0, el[k]}, 32'd0);
        end
        chk({tag, "_mat_valid"}, {31'd0, mat_valid}, 32'd0);
        chk({tag, "_frame_err"}, {31'd0, frame_err}, 32'd0);
        chk({tag, "_in_ready"}, {31'd0, in_ready}, {31'd0, !rst});
    endtask

    task automatic handoff(input string tag);
        mat_ready = 1'b1;
        tick(-1);
        chk({tag, "_mv_fall"}, {31'd0, mat_valid}, 32'd0);
        chk({tag, "_rdy_rise"}, {31'd0, in_ready}, 32'd1);
        mat_ready = 1'b0;
    endtask

    task automatic rand_frame();
        for (int k = 0; k < 20; k++) fw[k] = 16'($urandom);
    endtask

    initial begin
        logic [15:0] fw_snap [18];
        rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = '0; mat_ready = 1'b0;
        err_pulses = 0; err_word = -1;
        tick(-1); tick(-1); tick(-1);
        check_zero("reset");
        rst = 1'b0;
        #1;
        chk("reset_release_ready", {31'd0, in_ready}, 32'd1);

        // Words 1..18, back-to-back, consumer always ready.
        for (int k = 0; k < 18; k++) fw[k] = 16'(k + 1);
        mat_ready = 1'b1;
        send_frame(18, 17, 0);
        check_frame("count", 18, 17);
        for (int k = 0; k < 18; k++) fw_snap[k] = fw[k];
        chk("count_y11", y_of(el, 0, 0), y_of(fw_snap, 0, 0));
        chk("count_y11_const", y_of(el, 0, 0), 84);
        tick(-1);
        chk("count_mv_one_cycle", {31'd0, mat_valid}, 32'd0);
        chk("count_ready_back", {31'd0, in_ready}, 32'd1);
        mat_ready = 1'b0;

        // Identity A, B = -5..3, consumer stalls for 10 cycles while upstream pushes garbage.
        for (int k = 0; k < 9; k++) fw[k] = (k % 4 == 0) ? 16'd1 : 16'd0;
        for (int k = 0; k < 9; k++) fw[9+k] = 16'(k - 5);
        send_frame(18, 17, 0);
        check_frame("ident", 18, 17);
        for (int c = 0; c < 10; c++) begin
            chk("ident_hold_mv", {31'd0, mat_valid}, 32'd1);
            chk("ident_hold_rdy", {31'd0, in_ready}, 32'd0);
            for (int k = 0; k < 18; k++) begin
                if (el[k] !== fw[k]) chk($sformatf("ident_stable_el%0d", k), {16'd0, el[k]}, {16'd0, fw[k]});
            end
            if (c < 9) begin
                in_valid = 1'b1;
                in_data  = 16'($urandom);
                in_last  = 1'($urandom);
                tick(-1);
            end
        end
        in_valid = 1'b0; in_last = 1'b0;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                chk($sformatf("ident_y%0d%0d", r + 1, c + 1), y_of(el, r, c), int'($signed(fw[9+3*r+c])));
        handoff("ident");

        // Short frame (last on word 5), then a good random frame.
        rand_frame();
        send_frame(5, 4, 0);
        check_frame("short", 5, 4);
        rand_frame();
        send_frame(18, 17, 0);
        check_frame("after_short", 18, 17);
        handoff("after_short");

        // Long frame of 20 words, then a good random frame.
        rand_frame();
        send_frame(20, 19, 0);
        check_frame("long", 20, 19);
        rand_frame();
        send_frame(18, 17, 0);
        check_frame("after_long", 18, 17);
        handoff("after_long");

        // Extreme values with ~50% valid gaps.
        for (int k = 0; k < 18; k++) fw[k] = $urandom_range(1) ? 16'h8000 : 16'h7fff;
        send_frame(18, 17, 50);
        check_frame("extreme", 18, 17);
        for (int k = 0; k < 18; k++) fw_snap[k] = fw[k];
        chk("extreme_y22", y_of(el, 1, 1), y_of(fw_snap, 1, 1));
        handoff("extreme");

        // Reset after words 0..9 of a frame.
        rand_frame();
        send_frame(10, -1, 25);
        check_frame("mid", 10, -1);
        rst = 1'b1; in_valid = 1'b1; in_data = 16'hdead;
        #1;
        chk("mid_rst_ready", {31'd0, in_ready}, 32'd0);
        tick(-1);
        check_zero("mid_rst");
        rst = 1'b0; in_valid = 1'b0;
        #1;
        chk("mid_release_ready", {31'd0, in_ready}, 32'd1);
        err_pulses = 0;
        tick(-1);
        chk("mid_no_err", err_pulses, 0);
        rand_frame();
        send_frame(18, 17, 30);
        check_frame("after_mid", 18, 17);

        // Reset while holding a frame.
        rst = 1'b1;
        tick(-1);
        check_zero("hold_rst");
        rst = 1'b0;
        #1;
        chk("hold_release_ready", {31'd0, in_ready}, 32'd1);
        rand_frame();
        send_frame(18, 17, 0);
        check_frame("after_hold", 18, 17);
        handoff("after_hold");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
